// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, ACK handling, STOP.
// SCL is push-pull; SDA is open-drain via sda_oe_o. HALF = system clocks per SCL half-period.
module i2c_master #(
    parameter int HALF = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enb_i,
    input  logic       start_i,
    input  logic [6:0] addr_i,
    input  logic       rw_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       scl_o,
    output logic       sda_oe_o,
    input  logic       sda_in_i
);

    localparam int CW = $clog2(3 * HALF);
    localparam logic [CW-1:0] H_C      = CW'(HALF);
    localparam logic [CW-1:0] TWO_H    = CW'(2 * HALF);
    localparam logic [CW-1:0] SLOT_END = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] STOP_END = CW'(3 * HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    addr_q, addr_d;     // {addr, rw}
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ack_err_q, ack_err_d;
    logic          done_q, done_d;
    logic          scl, sda_oe;
    logic          high, slot_end;

    assign high     = (cnt_q >= H_C);
    assign slot_end = (cnt_q == SLOT_END);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        scl       = 1'b1;
        sda_oe    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_i && enb_i) begin
                    addr_d    = {addr_i, rw_i};
                    wdata_d   = wdata_i;
                    ack_err_d = 1'b0;
                    bit_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                // SDA falls half way through with SCL held high: the start condition.
                sda_oe = high;
                if (slot_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                scl    = high;
                sda_oe = ~addr_q[~bit_q];
                if (slot_end) begin
                    cnt_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_AACK;
                end
            end
            S_AACK: begin
                scl = high;
                if (slot_end) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (sda_in_i) begin
                        ack_err_d = 1'b1;
                        state_d   = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                scl    = high;
                sda_oe = addr_q[0] ? 1'b0 : ~wdata_q[~bit_q];
                if (slot_end) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    shift_d = {shift_q[6:0], sda_in_i};
                    if (bit_q == 3'd7) state_d = S_DACK;
                end
            end
            S_DACK: begin
                // On reads the master leaves SDA released here, i.e. it NACKs the only byte.
                scl = high;
                if (slot_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    if (addr_q[0])     rdata_d   = shift_q;
                    else if (sda_in_i) ack_err_d = 1'b1;
                end
            end
            S_STOP: begin
                scl    = high;
                sda_oe = (cnt_q < TWO_H);
                if (cnt_q == STOP_END) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdata_o   = rdata_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign ack_err_o = ack_err_q;
    assign scl_o     = scl;
    assign sda_oe_o  = sda_oe;

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master: the initiator end of the I2C link served by the team's I2C slave. It generates START, the 7-bit address with the R/W bit, one data byte (write or read), the ACK handling and STOP. SCL is derived from the system clock by a programmable divider. It sits between a local control interface (register or FSM) and the external open-drain SDA/SCL pins.

## Interface

- HALF, 4, system-clock cycles per SCL half-period; legal range ≥ 2.

- CLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENB  input  1  block enable; START is accepted only when ENB=1.
- START  input  1  one-cycle request to begin a transaction.
- ADDR  input  7  slave address, latched when START is accepted.
- RW  input  1  1 = read, 0 = write; latched with ADDR.
- WDATA  input  8  write byte; latched with ADDR.
- RDATA  output  8  byte received on a read; updated only at the end of a read.
- BUSY  output  1  high while a transaction is in progress.
- DONE  output  1  one-cycle pulse when a transaction ends.
- ACK_ERR  output  1  a NACK was received in the last transaction.
- SCL  output  1  bus clock, push-pull.
- SDA_OE  output  1  1 = pull SDA low; 0 = release SDA (external pull-up gives 1).
- SDA_IN  input  1  sampled SDA line level.

## Operation

- Reset state:
  - SCL=1, SDA_OE=0, BUSY=0, DONE=0, ACK_ERR=0, RDATA=8'h00.
  - FSM in IDLE.
- States: IDLE → START_C → ADDR(8 bits) → AACK → DATA(8 bits) → DACK → STOP_C → IDLE.
- Starting a transaction:
  - In IDLE, START=1 with ENB=1 latches ADDR, RW and WDATA, clears ACK_ERR, and sets BUSY on the next cycle.
  - START is ignored while BUSY=1 or when ENB=0.
  - ENB deasserted mid-transaction has no effect; the transaction runs to completion.
- START_C:
  - HALF cycles with SCL=1 and SDA released.
  - Then HALF cycles with SCL=1 and SDA_OE=1 (the start condition).
- Bit slot, used for every data/ACK bit (2·HALF cycles):
  - SCL=0 for HALF cycles; SDA_OE is updated on the first cycle of this low phase.
  - Then SCL=1 for HALF cycles; SDA_IN is sampled on the last cycle of the high phase.
- ADDR: sends ADDR[6]..ADDR[0] then RW, MSB first. Bit value 1 drives SDA_OE=0; bit value 0 drives SDA_OE=1.
- AACK:
  - SDA is released.
  - Sampled 0 = ACK → go to DATA.
  - Sampled 1 = NACK → set ACK_ERR and go straight to STOP_C. No data slots are clocked.
- DATA, write (RW=0): sends WDATA[7]..WDATA[0].
- DATA, read (RW=1):
  - SDA is released for all 8 slots.
  - Sampled bits shift MSB first into an internal register.
- DACK, write: SDA is released; a sampled 1 sets ACK_ERR.
- DACK, read:
  - The master sends NACK (SDA released), since only one byte is read.
  - RDATA is loaded from the shift register on the cycle that enters STOP_C.
- STOP_C (3·HALF cycles):
  - SCL=0 with SDA_OE=1 for HALF cycles.
  - SCL=1 with SDA_OE=1 for HALF cycles.
  - SCL=1 with SDA released for HALF cycles (the stop condition).
- End of transaction: the following cycle DONE=1 for one cycle, BUSY=0, and the FSM returns to IDLE.
- ACK_ERR holds its value until the next accepted START.
- RESET during any state: the next cycle gives the reset values (SCL=1, SDA released) and the FSM returns to IDLE. No STOP is generated. RDATA returns to 0.
- SDA changes only while SCL=0, except at the START/STOP edges.

## Timing

- Cycle 0 is the cycle in which START is accepted.
- Bus activity occupies cycles 1 … N; DONE and BUSY falling occur at cycle N+1.
- Full transaction: N = 2·HALF + 18·HALF + 18·HALF + 3·HALF = 41·HALF (164 for HALF=4).
- Address NACK: N = 23·HALF (92 for HALF=4).
- SCL period in the bit phase is 2·HALF cycles at 50 % duty.
- A new START may be accepted in the cycle DONE is high; BUSY then rises on the following cycle.

## Test plan

- Write, HALF=4:
  - Stimulus: ADDR=7'h5E, RW=0, WDATA=8'hA9; slave model ACKs both bytes.
  - Required: SDA bit stream 1011110_0, ACK, 10101001, ACK; DONE at cycle 165; ACK_ERR=0; SCL idles high.
- Read:
  - Stimulus: ADDR=7'h5E, RW=1; slave ACKs and returns 8'hBE.
  - Required: RDATA=8'hBE at DONE; SDA_OE=0 during all 8 data slots and the 9th slot; ACK_ERR=0.
- Address NACK:
  - Stimulus: slave model never pulls SDA low.
  - Required: ACK_ERR=1; exactly 9 SCL pulses after START; DONE at cycle 93; valid STOP observed.
- Write-data NACK:
  - Stimulus: slave ACKs the address, NACKs the data byte.
  - Required: ACK_ERR=1; DONE at cycle 165.
- Ignored requests:
  - Stimulus: START with ENB=0; START pulsed at cycle 50 of an active transaction.
  - Required: no bus activity from either; one DONE only.
- Reset mid-transaction:
  - Stimulus: RESET at cycle 100 of a read.
  - Required: next cycle SCL=1, SDA_OE=0, BUSY=0, RDATA=0, no DONE; a new write afterwards completes normally.
